// File: rtl/cpu_defs.sv
// cpu_defs: shared opcodes, flag layout, multiply sizing and pipeline control bundle
package cpu_defs;

  localparam int DATA_W    = 16;
  localparam int MUL_ITERS = 16;
  localparam int CNT_W     = $clog2(MUL_ITERS);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_INC  = 4'd6;
  localparam logic [3:0] OP_DEC  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SETC = 4'd10;
  localparam logic [3:0] OP_CLRC = 4'd11;
  localparam logic [3:0] OP_MOV  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;

  // ccr layout is {C,N,Z}
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       mem_push;
    logic       mem_pop;
    logic       reg_write;
    logic [2:0] dest;
  } ctrl_t;

  // Keep carry as given, derive N and Z from a result
  function automatic logic [2:0] zn_flags(input logic c, input logic [DATA_W-1:0] r);
    logic [2:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_N] = r[DATA_W-1];
    f[FLAG_Z] = (r == '0);
    return f;
  endfunction

endpackage

// File: rtl/alu.sv
// alu: single-cycle combinational ALU with next-flag computation (multiply handled outside)
module alu
  import cpu_defs::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        shamt,
  input  logic [2:0]        flags_in,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags_out
);

  logic          c;
  logic          zn;
  logic [DATA_W:0] wide;

  // Result, carry and whether Z/N follow the result; carry defaults to the held value
  always_comb begin
    result = a;
    c      = flags_in[FLAG_C];
    zn     = 1'b0;
    wide   = '0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
        zn     = 1'b1;
      end
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
        zn     = 1'b1;
      end
      OP_AND: begin
        result = a & b;
        zn     = 1'b1;
      end
      OP_OR: begin
        result = a | b;
        zn     = 1'b1;
      end
      OP_NOT: begin
        result = ~a;
        zn     = 1'b1;
      end
      OP_INC: begin
        wide   = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
        zn     = 1'b1;
      end
      OP_DEC: begin
        wide   = {1'b0, a} - {{DATA_W{1'b0}}, 1'b1};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
        zn     = 1'b1;
      end
      OP_SHL: begin
        wide   = {1'b0, a} << shamt;
        result = wide[DATA_W-1:0];
        c      = (shamt != 4'd0) ? wide[DATA_W] : flags_in[FLAG_C];
        zn     = 1'b1;
      end
      OP_SHR: begin
        wide   = {a, 1'b0} >> shamt;
        result = wide[DATA_W:1];
        c      = (shamt != 4'd0) ? wide[0] : flags_in[FLAG_C];
        zn     = 1'b1;
      end
      OP_SETC: c = 1'b1;
      OP_CLRC: c = 1'b0;
      OP_MOV:  result = b;
      default: ;
    endcase
  end

  assign flags_out = zn ? zn_flags(c, result)
                        : {c, flags_in[FLAG_N], flags_in[FLAG_Z]};

endmodule

// File: rtl/execute_stage.sv
// execute_stage: ALU execute with pipeline register, flags and iterative shift-add multiplier
module execute_stage
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [3:0]        shamt,
  input  logic              memory_read,
  input  logic              memory_write,
  input  logic              memory_push,
  input  logic              memory_pop,
  input  logic              RegWrite,
  input  logic [2:0]        reg_write_address,
  input  logic              flush,
  output logic [DATA_W-1:0] address_r,
  output logic [DATA_W-1:0] write_data_r,
  output logic              memory_read_r,
  output logic              memory_write_r,
  output logic              memory_push_r,
  output logic              memory_pop_r,
  output logic              RegWrite_r,
  output logic [2:0]        reg_write_address_r,
  output logic [2:0]        ccr,
  output logic              ex_busy
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] pend_data;
  ctrl_t             pend;
  ctrl_t             ctrl_in;
  ctrl_t             ctrl_r;
  logic [DATA_W-1:0] alu_result;
  logic [2:0]        alu_flags;

  alu u_alu (
    .op        (alu_op),
    .a         (operand_a),
    .b         (operand_b),
    .shamt     (shamt),
    .flags_in  (ccr),
    .result    (alu_result),
    .flags_out (alu_flags)
  );

  assign ctrl_in = '{memory_read, memory_write, memory_push, memory_pop, RegWrite, reg_write_address};

  assign memory_read_r       = ctrl_r.mem_read;
  assign memory_write_r      = ctrl_r.mem_write;
  assign memory_push_r       = ctrl_r.mem_push;
  assign memory_pop_r        = ctrl_r.mem_pop;
  assign RegWrite_r          = ctrl_r.reg_write;
  assign reg_write_address_r = ctrl_r.dest;
  assign ex_busy             = (state != S_IDLE);

  // Pipeline register plus multiply FSM; a multiply holds its controls until DONE and
  // emits bubbles meanwhile, and flush or reset drops it without ever emitting a result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      prod         <= '0;
      pend_data    <= '0;
      pend         <= '0;
      ctrl_r       <= '0;
      address_r    <= '0;
      write_data_r <= '0;
      ccr          <= '0;
    end else if (flush) begin
      state  <= S_IDLE;
      cnt    <= '0;
      prod   <= '0;
      ctrl_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (alu_op == OP_MUL) begin
            state     <= S_MUL;
            cnt       <= '0;
            prod      <= '0;
            mul_a     <= operand_a;
            mul_b     <= operand_b;
            pend      <= ctrl_in;
            pend_data <= operand_a;
            ctrl_r    <= '0;
          end else begin
            address_r    <= alu_result;
            write_data_r <= operand_a;
            ctrl_r       <= ctrl_in;
            ccr          <= alu_flags;
          end
        end
        S_MUL: begin
          prod   <= prod + (mul_b[0] ? mul_a : '0);
          mul_a  <= mul_a << 1;
          mul_b  <= mul_b >> 1;
          cnt    <= cnt + 1'b1;
          ctrl_r <= '0;
          if (cnt == CNT_W'(MUL_ITERS - 1)) state <= S_DONE;
        end
        S_DONE: begin
          address_r    <= prod;
          write_data_r <= pend_data;
          ctrl_r       <= pend;
          ccr          <= zn_flags(ccr[FLAG_C], prod);
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vectors with hand-computed expectations for execute_stage
module tb_execute_stage;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  alu_op = '0;
  logic [15:0] operand_a = '0;
  logic [15:0] operand_b = '0;
  logic [3:0]  shamt = '0;
  logic        memory_read = 1'b0;
  logic        memory_write = 1'b0;
  logic        memory_push = 1'b0;
  logic        memory_pop = 1'b0;
  logic        RegWrite = 1'b0;
  logic [2:0]  reg_write_address = '0;
  logic        flush = 1'b0;
  logic [15:0] address_r;
  logic [15:0] write_data_r;
  logic        memory_read_r;
  logic        memory_write_r;
  logic        memory_push_r;
  logic        memory_pop_r;
  logic        RegWrite_r;
  logic [2:0]  reg_write_address_r;
  logic [2:0]  ccr;
  logic        ex_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_n;

  execute_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .alu_op              (alu_op),
    .operand_a           (operand_a),
    .operand_b           (operand_b),
    .shamt               (shamt),
    .memory_read         (memory_read),
    .memory_write        (memory_write),
    .memory_push         (memory_push),
    .memory_pop          (memory_pop),
    .RegWrite            (RegWrite),
    .reg_write_address   (reg_write_address),
    .flush               (flush),
    .address_r           (address_r),
    .write_data_r        (write_data_r),
    .memory_read_r       (memory_read_r),
    .memory_write_r      (memory_write_r),
    .memory_push_r       (memory_push_r),
    .memory_pop_r        (memory_pop_r),
    .RegWrite_r          (RegWrite_r),
    .reg_write_address_r (reg_write_address_r),
    .ccr                 (ccr),
    .ex_busy             (ex_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh);
    alu_op    = op;
    operand_a = a;
    operand_b = b;
    shamt     = sh;
    step();
  endtask

  initial begin
    #3;
    check("rst_addr", address_r, 16'h0000);
    check("rst_ccr", ccr, 3'b000);
    check("rst_busy", ex_busy, 1'b0);
    check("rst_rw", RegWrite_r, 1'b0);
    #4 reset = 1'b1;
    RegWrite = 1'b1;
    reg_write_address = 3'd3;
    issue(OP_ADD, 16'hFFFF, 16'h0001, 4'd0);
    check("add_addr", address_r, 16'h0000);
    check("add_ccr", ccr, 3'b101);
    check("add_rw", RegWrite_r, 1'b1);
    check("add_dest", reg_write_address_r, 3'd3);
    issue(OP_SUB, 16'h0003, 16'h0005, 4'd0);
    check("sub_addr", address_r, 16'hFFFE);
    check("sub_ccr", ccr, 3'b110);
    issue(OP_SHL, 16'h8001, 16'h0000, 4'd1);
    check("shl_addr", address_r, 16'h0002);
    check("shl_ccr", ccr, 3'b100);
    RegWrite = 1'b0;
    memory_write = 1'b1;
    issue(OP_MOV, 16'h00AA, 16'h0010, 4'd0);
    check("mov_addr", address_r, 16'h0010);
    check("mov_wdata", write_data_r, 16'h00AA);
    check("mov_mw", memory_write_r, 1'b1);
    check("mov_rw", RegWrite_r, 1'b0);
    check("mov_ccr", ccr, 3'b100);
    memory_write = 1'b0;
    issue(OP_AND, 16'hF0F0, 16'h0FF0, 4'd0);
    check("and_addr", address_r, 16'h00F0);
    check("and_ccr", ccr, 3'b100);
    check("and_mw", memory_write_r, 1'b0);
    issue(OP_CLRC, 16'h0000, 16'h0000, 4'd0);
    check("clrc_ccr", ccr, 3'b000);
    issue(OP_SETC, 16'h0000, 16'h0000, 4'd0);
    check("setc_ccr", ccr, 3'b100);
    issue(OP_SHR, 16'h0001, 16'h0000, 4'd1);
    check("shr_addr", address_r, 16'h0000);
    check("shr_ccr", ccr, 3'b101);
    issue(OP_SHL, 16'h8000, 16'h0000, 4'd0);
    check("shl0_addr", address_r, 16'h8000);
    check("shl0_ccr", ccr, 3'b110);
    issue(OP_CLRC, 16'h0000, 16'h0000, 4'd0);
    issue(OP_DEC, 16'h0000, 16'h0000, 4'd0);
    check("dec_addr", address_r, 16'hFFFF);
    check("dec_ccr", ccr, 3'b110);
    issue(OP_INC, 16'hFFFF, 16'h0000, 4'd0);
    check("inc_addr", address_r, 16'h0000);
    check("inc_ccr", ccr, 3'b101);
    issue(OP_NOT, 16'h00FF, 16'h0000, 4'd0);
    check("not_addr", address_r, 16'hFF00);
    check("not_ccr", ccr, 3'b110);
    issue(OP_OR, 16'h0000, 16'h0000, 4'd0);
    check("or_addr", address_r, 16'h0000);
    check("or_ccr", ccr, 3'b101);
    RegWrite = 1'b1;
    reg_write_address = 3'd6;
    issue(4'd14, 16'h1234, 16'h5678, 4'd0);
    check("op14_addr", address_r, 16'h1234);
    check("op14_ccr", ccr, 3'b101);
    check("op14_rw", RegWrite_r, 1'b1);

    reg_write_address = 3'd5;
    issue(OP_MUL, 16'h0012, 16'h0034, 4'd0);
    busy_n = 0;
    while (ex_busy && busy_n < 40) begin
      busy_n++;
      check("mul_bubble", RegWrite_r, 1'b0);
      step();
    end
    check("mul_busy_cycles", busy_n, 17);
    check("mul_addr", address_r, 16'h03A8);
    check("mul_wdata", write_data_r, 16'h0012);
    check("mul_rw", RegWrite_r, 1'b1);
    check("mul_dest", reg_write_address_r, 3'd5);
    check("mul_ccr", ccr, 3'b100);

    issue(OP_MUL, 16'h0003, 16'h0004, 4'd0);
    check("fl_busy_start", ex_busy, 1'b1);
    repeat (4) step();
    flush = 1'b1;
    step();
    check("fl_busy", ex_busy, 1'b0);
    check("fl_rw", RegWrite_r, 1'b0);
    check("fl_ccr", ccr, 3'b100);
    repeat (20) step();
    check("fl_addr", address_r, 16'h03A8);
    check("fl_busy_hold", ex_busy, 1'b0);
    flush = 1'b0;

    issue(OP_MUL, 16'h0003, 16'h0004, 4'd0);
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    check("ar_addr", address_r, 16'h0000);
    check("ar_ccr", ccr, 3'b000);
    check("ar_busy", ex_busy, 1'b0);
    check("ar_rw", RegWrite_r, 1'b0);
    alu_op    = OP_ADD;
    operand_a = 16'h0002;
    operand_b = 16'h0002;
    RegWrite  = 1'b0;
    #2 reset = 1'b1;
    step();
    check("ar_add_addr", address_r, 16'h0004);
    check("ar_add_ccr", ccr, 3'b000);
    check("ar_add_busy", ex_busy, 1'b0);
    issue(OP_NOP, 16'h0004, 16'h0000, 4'd0);
    repeat (20) step();
    check("ar_no_result", address_r, 16'h0004);
    check("ar_idle", ex_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
